muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit owning the HI/LO register pair; responder to the execute stage,

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = 32;

  // Execute-stage operation codes; 6 and 7 are reserved and act as no-ops.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Ops that run through the iterative datapath.
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
//  mult: acc = {partial product, remaining multiplier bits}; add opnd when
//        the multiplier LSB is set, then shift the whole thing right.
//  div : acc = {partial remainder, dividend/quotient bits}; shift left one,
//        trial-subtract the divisor, keep the difference if it did not borrow
//        and shift the quotient bit into the bottom.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Single-step add-shift / restoring subtract-shift.
  always_comb begin
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    // When ge holds the true difference is below opnd, so WIDTH bits suffice.
    diff    = shifted[WIDTH-1:0] - opnd;
    acc_o   = '0;
    if (is_div) begin
      acc_o = {(ge ? diff : shifted[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
    end else if (acc_i[0]) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Signed ops run on magnitudes
// and apply the sign correction in a single FIX cycle at the end.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITERS = MD_ITERS
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iAbort,
  input  logic             iRdReq,
  input  logic             iRdSel,
  output logic [WIDTH-1:0] oRdData,
  output logic             oBusy,
  output logic             oStall,
  output logic             oDivZero
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  state_e             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod;
  logic [WIDTH-1:0]   opnd, hi, lo;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, res_hi, res_lo;
  logic               is_div, neg_res, neg_dvd, dz;
  logic               start_md, start_mt, sgn;

  // Request decode: only accepted while idle, and a flush kills it outright.
  always_comb begin
    start_md = 1'b0;
    start_mt = 1'b0;
    if (state == ST_IDLE && iStart && !iAbort) begin
      start_md = is_arith_op(iOp);
      start_mt = (iOp == OP_MTHI) || (iOp == OP_MTLO);
    end
    sgn   = is_signed_op(iOp);
    a_mag = (sgn && iA[WIDTH-1]) ? (~iA + 1'b1) : iA;
    b_mag = (sgn && iB[WIDTH-1]) ? (~iB + 1'b1) : iB;
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: flush returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    if (iAbort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start_md) state_nxt = ST_CALC;
        ST_CALC: if (cnt == CW'(ITERS - 1)) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs and the combinational read/interlock paths.
  always_comb begin
    oBusy   = (state != ST_IDLE);
    oStall  = oBusy & (iStart | iRdReq);
    oRdData = iRdSel ? hi : lo;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc_i  (acc),
    .opnd   (opnd),
    .acc_o  (acc_step)
  );

  // Operand/sign latches and the iteration counter.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_dvd <= 1'b0;
      dz      <= 1'b0;
    end else if (start_md) begin
      cnt     <= '0;
      is_div  <= is_div_op(iOp);
      // Mult keeps the multiplier in the low half and adds the multiplicand;
      // div keeps the dividend in the low half and subtracts the divisor.
      acc     <= is_div_op(iOp) ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      opnd    <= is_div_op(iOp) ? b_mag : a_mag;
      neg_res <= sgn & (iA[WIDTH-1] ^ iB[WIDTH-1]);
      neg_dvd <= sgn & is_div_op(iOp) & iA[WIDTH-1];
      dz      <= is_div_op(iOp) & (iB == '0);
    end else if (state == ST_CALC && !iAbort) begin
      acc <= acc_step;
      cnt <= cnt + 1'b1;
    end
  end

  // Sign correction. A zero divisor leaves rem = |dividend|, which the
  // dividend-sign fix turns back into the raw dividend; LO is forced to ones.
  always_comb begin
    prod   = neg_res ? (~acc + 1'b1) : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_hi = neg_dvd ? (~rem + 1'b1) : rem;
      res_lo = dz ? {WIDTH{1'b1}} : (neg_res ? (~quo + 1'b1) : quo);
    end
  end

  // HI/LO: direct moves from IDLE, or the corrected result out of FIX.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      hi <= '0;
      lo <= '0;
    end else if (start_mt) begin
      if (iOp == OP_MTHI) hi <= iA;
      else                lo <= iA;
    end else if (state == ST_FIX && !iAbort) begin
      hi <= res_hi;
      lo <= res_lo;
    end
  end

  assign oDivZero = dz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: each task drives one scenario and checks inline.
module tb_muldiv_unit;

  logic        iCLK = 1'b0;
  logic        iRST, iStart, iAbort, iRdReq, iRdSel;
  logic [2:0]  iOp;
  logic [31:0] iA, iB, oRdData;
  logic        oBusy, oStall, oDivZero;

  int n_chk = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32), .ITERS(32)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
    .iAbort(iAbort), .iRdReq(iRdReq), .iRdSel(iRdSel), .oRdData(oRdData),
    .oBusy(oBusy), .oStall(oStall), .oDivZero(oDivZero)
  );

  always #5 iCLK = ~iCLK;

  // All tasks enter and leave 1ns after a rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    iOp = op; iA = a; iB = b; iStart = 1'b1;
    @(posedge iCLK); #1;
    iStart = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (oBusy && n < 100) begin
      n++;
      @(posedge iCLK); #1;
    end
  endtask

  task automatic rd(input logic sel, output logic [31:0] d);
    iRdSel = sel; #1;
    d = oRdData;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    iRST = 1'b0; iStart = 1'b0; iAbort = 1'b0; iRdReq = 1'b0; iRdSel = 1'b0;
    iOp = 3'd0; iA = '0; iB = '0;
    repeat (3) @(posedge iCLK);
    #1;
    n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", oBusy); end
    n_chk++; if (oDivZero !== 1'b0) begin n_fail++; $display("FAIL rst_dz got %b want 0", oDivZero); end
    rd(1'b0, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_lo got %h want 0", d); end
    rd(1'b1, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_hi got %h want 0", d); end
    @(posedge iCLK); #1;
    iRST = 1'b1;
    @(posedge iCLK); #1;
  endtask

  task automatic test_mult();
    int n; logic [31:0] d;
    issue(3'd0, 32'hFFFFFFFD, 32'd7);
    wait_idle(n);
    n_chk++; if (n !== 33) begin n_fail++; $display("FAIL mult_busy got %0d want 33", n); end
    rd(1'b1, d);
    n_chk++; if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", d); end
    rd(1'b0, d);
    n_chk++; if (d !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo got %h want ffffffeb", d); end
    @(posedge iCLK); #1;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    n_chk++; if (n !== 33) begin n_fail++; $display("FAIL multu_busy got %0d want 33", n); end
    rd(1'b1, d);
    n_chk++; if (d !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", d); end
    rd(1'b0, d);
    n_chk++; if (d !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo got %h want 1", d); end
    @(posedge iCLK); #1;
  endtask

  task automatic test_div();
    int n; logic [31:0] d;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    n_chk++; if (n !== 33) begin n_fail++; $display("FAIL div_busy got %0d want 33", n); end
    rd(1'b0, d);
    n_chk++; if (d !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", d); end
    rd(1'b1, d);
    n_chk++; if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", d); end
    @(posedge iCLK); #1;
    issue(3'd3, 32'd7, 32'd2);
    wait_idle(n);
    rd(1'b0, d);
    n_chk++; if (d !== 32'd3) begin n_fail++; $display("FAIL divu_lo got %h want 3", d); end
    rd(1'b1, d);
    n_chk++; if (d !== 32'd1) begin n_fail++; $display("FAIL divu_hi got %h want 1", d); end
    @(posedge iCLK); #1;
  endtask

  task automatic test_div_corner();
    int n; logic [31:0] d;
    issue(3'd2, 32'h00001234, 32'd0);
    wait_idle(n);
    n_chk++; if (n !== 33) begin n_fail++; $display("FAIL dz_busy got %0d want 33", n); end
    n_chk++; if (oDivZero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", oDivZero); end
    rd(1'b0, d);
    n_chk++; if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dz_lo got %h want ffffffff", d); end
    rd(1'b1, d);
    n_chk++; if (d !== 32'h00001234) begin n_fail++; $display("FAIL dz_hi got %h want 1234", d); end
    @(posedge iCLK); #1;
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    n_chk++; if (oDivZero !== 1'b0) begin n_fail++; $display("FAIL ovf_dz got %b want 0", oDivZero); end
    rd(1'b0, d);
    n_chk++; if (d !== 32'h80000000) begin n_fail++; $display("FAIL ovf_lo got %h want 80000000", d); end
    rd(1'b1, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL ovf_hi got %h want 0", d); end
    @(posedge iCLK); #1;
  endtask

  task automatic test_move();
    logic [31:0] d;
    issue(3'd5, 32'h0000A5A5, 32'h0);
    n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy got %b want 0", oBusy); end
    rd(1'b0, d);
    n_chk++; if (d !== 32'h0000A5A5) begin n_fail++; $display("FAIL mtlo_lo got %h want a5a5", d); end
    @(posedge iCLK); #1;
    issue(3'd4, 32'h5A5A0000, 32'h0);
    rd(1'b1, d);
    n_chk++; if (d !== 32'h5A5A0000) begin n_fail++; $display("FAIL mthi_hi got %h want 5a5a0000", d); end
    rd(1'b0, d);
    n_chk++; if (d !== 32'h0000A5A5) begin n_fail++; $display("FAIL mthi_lo_kept got %h want a5a5", d); end
    @(posedge iCLK); #1;
    // Reserved op touches nothing.
    issue(3'd6, 32'h12345678, 32'h9);
    n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rsvd_busy got %b want 0", oBusy); end
    rd(1'b0, d);
    n_chk++; if (d !== 32'h0000A5A5) begin n_fail++; $display("FAIL rsvd_lo got %h want a5a5", d); end
    @(posedge iCLK); #1;
  endtask

  task automatic test_stall();
    int n; logic [31:0] d;
    iRdReq = 1'b1; #1;
    n_chk++; if (oStall !== 1'b0) begin n_fail++; $display("FAIL idle_stall got %b want 0", oStall); end
    iRdReq = 1'b0;
    @(posedge iCLK); #1;
    issue(3'd2, 32'd20, 32'hFFFFFFFA);
    repeat (4) begin @(posedge iCLK); #1; end
    iRdReq = 1'b1; #1;
    n_chk++; if (oStall !== 1'b1) begin n_fail++; $display("FAIL rd_stall got %b want 1", oStall); end
    iRdReq = 1'b0; #1;
    n_chk++; if (oStall !== 1'b0) begin n_fail++; $display("FAIL nostall got %b want 0", oStall); end
    // A start while busy is ignored.
    iOp = 3'd5; iA = 32'hDEADBEEF; iStart = 1'b1; #1;
    n_chk++; if (oStall !== 1'b1) begin n_fail++; $display("FAIL start_stall got %b want 1", oStall); end
    @(posedge iCLK); #1;
    iStart = 1'b0;
    wait_idle(n);
    rd(1'b0, d);
    n_chk++; if (d !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL stall_lo got %h want fffffffd", d); end
    rd(1'b1, d);
    n_chk++; if (d !== 32'd2) begin n_fail++; $display("FAIL stall_hi got %h want 2", d); end
    @(posedge iCLK); #1;
  endtask

  task automatic test_abort();
    logic [31:0] d;
    issue(3'd4, 32'h11111111, 32'h0);
    issue(3'd5, 32'h22222222, 32'h0);
    issue(3'd0, 32'd5, 32'd6);
    repeat (9) begin @(posedge iCLK); #1; end
    iAbort = 1'b1;
    @(posedge iCLK); #1;
    iAbort = 1'b0;
    n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", oBusy); end
    repeat (40) begin @(posedge iCLK); #1; end
    rd(1'b1, d);
    n_chk++; if (d !== 32'h11111111) begin n_fail++; $display("FAIL abort_hi got %h want 11111111", d); end
    rd(1'b0, d);
    n_chk++; if (d !== 32'h22222222) begin n_fail++; $display("FAIL abort_lo got %h want 22222222", d); end
    @(posedge iCLK); #1;
    // Flush in IDLE still suppresses a same-cycle move.
    iAbort = 1'b1;
    issue(3'd5, 32'h33333333, 32'h0);
    iAbort = 1'b0;
    rd(1'b0, d);
    n_chk++; if (d !== 32'h22222222) begin n_fail++; $display("FAIL abort_mt got %h want 22222222", d); end
    @(posedge iCLK); #1;
  endtask

  task automatic test_back_to_back();
    int n; logic [31:0] d;
    issue(3'd1, 32'd5, 32'd6);
    wait_idle(n);
    rd(1'b0, d);
    n_chk++; if (d !== 32'd30) begin n_fail++; $display("FAIL b2b_mul_lo got %h want 1e", d); end
    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    n_chk++; if (n !== 33) begin n_fail++; $display("FAIL b2b_busy got %0d want 33", n); end
    rd(1'b0, d);
    n_chk++; if (d !== 32'd14) begin n_fail++; $display("FAIL b2b_div_lo got %h want e", d); end
    rd(1'b1, d);
    n_chk++; if (d !== 32'd2) begin n_fail++; $display("FAIL b2b_div_hi got %h want 2", d); end
    @(posedge iCLK); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    issue(3'd2, 32'h00000055, 32'd0);
    n_chk++; if (oDivZero !== 1'b1) begin n_fail++; $display("FAIL mid_dz_pre got %b want 1", oDivZero); end
    repeat (5) begin @(posedge iCLK); #1; end
    #2 iRST = 1'b0; #1;
    n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", oBusy); end
    n_chk++; if (oDivZero !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dz got %b want 0", oDivZero); end
    rd(1'b0, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_rst_lo got %h want 0", d); end
    rd(1'b1, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_rst_hi got %h want 0", d); end
    @(posedge iCLK); #1;
    iRST = 1'b1;
    @(posedge iCLK); #1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_corner();
    test_move();
    test_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
